mc_pwm_scheduler: RTL and testbench
===================================

Name: mc_pwm_scheduler

Overview:
- Switching-period scheduler for the 3x3 matrix converter.
- Drives the 2-bit DesiredLoad input of the three per-output-leg commutation FSMs (legs 0..2).
- Within each PWM period, each leg dwells on source phase A, then B, then C for programmed durations.
- Period and duty configuration arrives over a valid/ready handshake into a shadow register. The shadow register is applied only at period boundaries.

Parameters:
- CNT_W, 12, width of period and duty values in clk cycles.
- MIN_DWELL, 24, minimum non-zero segment length in clk cycles. Must exceed the FSM commutation time: TDOFF+TDON+2 = 12.

Ports:
- clk  in  1  system clock, 50 MHz.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  run enable.
- cfg_valid  in  1  configuration offered.
- cfg_ready  out  1  shadow register empty, can accept a configuration.
- cfg_period  in  CNT_W  PWM period in cycles.
- cfg_duty  in  6*CNT_W  per leg {dB,dA}. Leg k occupies bits [2k*CNT_W +: 2*CNT_W], with dA in the low half. dC = period-dA-dB.
- load0, load1, load2  out  2 each  DesiredLoad per leg: 01=A, 10=B, 11=C, 00=NUL (hold).
- period_start  out  1  one-cycle pulse, first cycle of each period.
- cfg_err  out  1  one-cycle pulse when a configuration is rejected.
- running  out  1  high in RUN.

Behaviour:
- Reset values (rst low, async): state=IDLE, cnt=0, shadow empty, active config invalid, load0..2=00, period_start=0, cfg_err=0, running=0, cfg_ready=1.
- Handshake:
  - Transfer occurs on cfg_valid&&cfg_ready. Captured data sets shadow_full.
  - cfg_ready = !shadow_full.
  - cfg_valid held with cfg_ready low: data is not captured and the source must hold it.
- Validation at capture, widths CNT_W+1, no wrap:
  - Reject if period < 2*MIN_DWELL, or if any leg has dA+dB > period.
  - Rejected: cfg_err pulses 1 cycle the following cycle, shadow stays empty.
- States:
  - IDLE: outputs 00.
    - If shadow_full: copy shadow to active, clear shadow_full.
    - If en && active valid: go to RUN with cnt=0.
  - RUN:
    - cnt increments each cycle, wraps at period-1 to 0.
    - At wrap: if shadow_full, load shadow into active (same edge), clear shadow_full.
    - At wrap: if en low, go to IDLE instead of wrapping.
    - en deassertion mid-period has no effect until the period ends.
- Segment decode per leg, using the active config, evaluated at each new cnt:
  - Effective durations: any of dA, dB below MIN_DWELL and non-zero is treated as 0. The time goes to the next segment.
  - If dC is below MIN_DWELL and non-zero, it merges into B. If B is 0, it merges into A.
  - Output A while cnt<eA, B while cnt<eA+eB, else C.
  - Zero-length segments never appear on the output.
- Latency:
  - load outputs and period_start are registered.
  - The first RUN cycle (cnt=0) shows the cnt=0 segment and period_start=1.
  - Outputs are held steady between segment boundaries.
- Simultaneous capture and apply in the same cycle: the apply uses the old shadow, then the new data is captured. In practice, with cfg_ready=!shadow_full, capture and apply cannot coincide.
- Reset mid-operation: immediate return to reset values. The FSMs see 00 (hold) and their own reset forces BAD.

Optional Feature:
- Macro: MCSCHED_SYMMETRIC_EN.
- Defined:
  - Odd periods use the order C,B,A with the same durations, giving an A-B-C|C-B-A pattern.
  - One commutation per leg is saved at each boundary.
  - A parity bit toggles at each wrap and clears on entry to RUN.
- Undefined: every period uses the order A,B,C and no parity register exists.

Test Plan:
- Reset, then period=100, all legs dA=30,dB=30, en=1 -> period_start at cycles 0,100,200. Each load: 01 for cycles 0-29, 10 for 30-59, 11 for 60-99.
- Leg0 dA=10 (<MIN_DWELL), dB=40, period=100 -> load0 never 01; 10 for cycles 0-49, 11 for 50-99.
- Leg1 dA=60,dB=30 (dC=10), period=100 -> load1 01 for cycles 0-59, 10 for 60-99, never 11.
- cfg dA=70,dB=40, period=100 -> cfg_err 1-cycle pulse, cfg_ready stays 1, schedule unchanged.
- New config offered mid-period -> cfg_ready drops. New durations take effect exactly at the next period_start. cfg_ready returns to 1 the same cycle.
- en dropped at cycle 150 of 100-cycle periods -> outputs 00 and running=0 from cycle 200. With MCSCHED_SYMMETRIC_EN, cycles 100-199 show C,B,A order.

Source files
------------

// File: rtl/mc_pwm_scheduler.sv
// ---------------------------------------------------------------------------
// mc_pwm_scheduler
//
// Switching-period scheduler for the 3x3 matrix converter. It produces the
// 2-bit DesiredLoad code for the three output-leg commutation FSMs. Within
// every PWM period each leg dwells on source phase A, then B, then C for the
// programmed durations. New period/duty settings arrive over a valid/ready
// handshake into a one-entry shadow register. The shadow register is only
// copied into the active configuration at a period boundary, or while idle.
//
// Optional feature macro: MCSCHED_SYMMETRIC_EN
//   When defined, odd-numbered periods run in the order C,B,A with the same
//   durations. This gives an A-B-C|C-B-A pattern and saves one commutation per
//   leg at each boundary. A parity register tracks odd/even periods.
//   When undefined, every period runs A,B,C and no parity register exists.
//
// Ports:
//   clk           system clock (50 MHz)
//   rst           asynchronous reset, active low
//   en            run enable; sampled only at period boundaries while running
//   cfg_valid     configuration offered by the source
//   cfg_ready     shadow register empty, a configuration can be accepted
//   cfg_period    PWM period in clk cycles
//   cfg_duty      per leg {dB,dA}. Leg k is at [2k*CNT_W +: 2*CNT_W] with dA
//                 in the low half. dC is implied as period-dA-dB.
//   load0..load2  DesiredLoad per leg: 01=A, 10=B, 11=C, 00=hold
//   period_start  one-cycle pulse on the first cycle of each period
//   cfg_err       one-cycle pulse after a configuration is rejected
//   running       high while the scheduler is in RUN
// ---------------------------------------------------------------------------
module mc_pwm_scheduler #(
    parameter int CNT_W     = 12,
    parameter int MIN_DWELL = 24
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [CNT_W-1:0]     cfg_period,
    input  logic [6*CNT_W-1:0]   cfg_duty,
    output logic [1:0]           load0,
    output logic [1:0]           load1,
    output logic [1:0]           load2,
    output logic                 period_start,
    output logic                 cfg_err,
    output logic                 running
);

    // Comparisons use one extra bit so that dA+dB cannot wrap.
    localparam logic [CNT_W:0] MIN_W      = (CNT_W+1)'(MIN_DWELL);
    localparam logic [CNT_W:0] MIN_PERIOD = (CNT_W+1)'(2*MIN_DWELL);

    localparam logic [1:0] LD_A = 2'b01;
    localparam logic [1:0] LD_B = 2'b10;
    localparam logic [1:0] LD_C = 2'b11;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t               state;
    logic [CNT_W-1:0]     cnt;

    logic                 shadow_full;
    logic [CNT_W-1:0]     sh_period;
    logic [6*CNT_W-1:0]   sh_duty;

    logic                 act_valid;
    logic [CNT_W-1:0]     act_period;
    logic [6*CNT_W-1:0]   act_duty;

    logic                 cfg_ok;
    logic [CNT_W:0]       leg_sum;

    logic                 at_wrap;
    logic                 apply;
    logic [CNT_W-1:0]     next_period;
    logic [6*CNT_W-1:0]   next_duty;
    logic                 next_valid;
    logic [CNT_W-1:0]     next_cnt;
    logic                 rev;
    logic [1:0]           dec0;
    logic [1:0]           dec1;
    logic [1:0]           dec2;

`ifdef MCSCHED_SYMMETRIC_EN
    logic                 parity;
    logic                 parity_next;
`endif

    // Map a position inside the period onto the phase one leg should drive.
    // The dwell lengths are first turned into two boundaries, bound_a (end of
    // A) and bound_b (end of B). Short segments are folded into neighbours so
    // that a dwell shorter than the commutation time never reaches the FSMs:
    //   - a short A hands its time to B, or to C when B is also dropped
    //   - a short B hands its time to C
    //   - a short C is absorbed by B, or by A when B is dropped
    // In reverse order the same lengths are laid out as C, B, A.
    function automatic logic [1:0] decode_leg(
        input logic [CNT_W-1:0]   pos,
        input logic [CNT_W-1:0]   period,
        input logic [2*CNT_W-1:0] duty,
        input logic               reverse
    );
        logic [CNT_W:0] da;
        logic [CNT_W:0] db;
        logic [CNT_W:0] dc;
        logic [CNT_W:0] per;
        logic [CNT_W:0] p;
        logic [CNT_W:0] bound_a;
        logic [CNT_W:0] bound_b;
        logic           a_on;
        logic           b_on;
        logic           c_short;
        logic [1:0]     result;

        da      = {1'b0, duty[CNT_W-1:0]};
        db      = {1'b0, duty[2*CNT_W-1:CNT_W]};
        per     = {1'b0, period};
        p       = {1'b0, pos};
        dc      = per - da - db;
        a_on    = (da >= MIN_W);
        b_on    = (db >= MIN_W);
        c_short = (dc != '0) && (dc < MIN_W);

        bound_a = a_on ? da : '0;
        bound_b = b_on ? (da + db) : bound_a;

        if (c_short) begin
            if (b_on) begin
                bound_b = per;
            end else if (a_on) begin
                bound_a = per;
                bound_b = per;
            end
        end

        if (!reverse) begin
            if (p < bound_a) begin
                result = LD_A;
            end else if (p < bound_b) begin
                result = LD_B;
            end else begin
                result = LD_C;
            end
        end else begin
            if (p < (per - bound_b)) begin
                result = LD_C;
            end else if (p < (per - bound_a)) begin
                result = LD_B;
            end else begin
                result = LD_A;
            end
        end
        return result;
    endfunction

    assign cfg_ready = !shadow_full;

    // Validation of the offered configuration. The period must leave room for
    // two minimum dwells, and no leg may ask for more A+B time than the period.
    always_comb begin
        cfg_ok  = ({1'b0, cfg_period} >= MIN_PERIOD);
        leg_sum = '0;
        for (int k = 0; k < 3; k++) begin
            leg_sum = {1'b0, cfg_duty[2*k*CNT_W +: CNT_W]}
                    + {1'b0, cfg_duty[(2*k+1)*CNT_W +: CNT_W]};
            if (leg_sum > {1'b0, cfg_period}) begin
                cfg_ok = 1'b0;
            end
        end
    end

    // Next-cycle view of the schedule. The outputs are registered, so the
    // decode runs on the counter value and configuration that become current
    // at the coming edge. This lets a freshly applied shadow drive the very
    // first cycle of its period.
    always_comb begin
        at_wrap     = (state == RUN) && (cnt == act_period - CNT_W'(1));
        apply       = shadow_full && ((state == IDLE) || at_wrap);
        next_period = apply ? sh_period : act_period;
        next_duty   = apply ? sh_duty : act_duty;
        next_valid  = apply || act_valid;
        next_cnt    = ((state == RUN) && !at_wrap) ? (cnt + CNT_W'(1)) : '0;
`ifdef MCSCHED_SYMMETRIC_EN
        parity_next = parity;
        if (state == IDLE) begin
            parity_next = 1'b0;
        end else if (at_wrap) begin
            parity_next = ~parity;
        end
        rev = parity_next;
`else
        rev = 1'b0;
`endif
        dec0 = decode_leg(next_cnt, next_period, next_duty[0*CNT_W +: 2*CNT_W], rev);
        dec1 = decode_leg(next_cnt, next_period, next_duty[2*CNT_W +: 2*CNT_W], rev);
        dec2 = decode_leg(next_cnt, next_period, next_duty[4*CNT_W +: 2*CNT_W], rev);
    end

    // Scheduler state machine with handshake, shadow/active configuration and
    // registered outputs. The apply clears shadow_full before a capture can set
    // it again. Because capture is only possible while the shadow is empty, the
    // two never coincide in practice.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            cnt          <= '0;
            shadow_full  <= 1'b0;
            sh_period    <= '0;
            sh_duty      <= '0;
            act_valid    <= 1'b0;
            act_period   <= '0;
            act_duty     <= '0;
            load0        <= 2'b00;
            load1        <= 2'b00;
            load2        <= 2'b00;
            period_start <= 1'b0;
            cfg_err      <= 1'b0;
            running      <= 1'b0;
`ifdef MCSCHED_SYMMETRIC_EN
            parity       <= 1'b0;
`endif
        end else begin
            cfg_err <= 1'b0;

            if (apply) begin
                act_period  <= sh_period;
                act_duty    <= sh_duty;
                act_valid   <= 1'b1;
                shadow_full <= 1'b0;
            end

            if (cfg_valid && !shadow_full) begin
                if (cfg_ok) begin
                    sh_period   <= cfg_period;
                    sh_duty     <= cfg_duty;
                    shadow_full <= 1'b1;
                end else begin
                    cfg_err <= 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    if (en && next_valid) begin
                        state        <= RUN;
                        cnt          <= '0;
                        load0        <= dec0;
                        load1        <= dec1;
                        load2        <= dec2;
                        period_start <= 1'b1;
                        running      <= 1'b1;
`ifdef MCSCHED_SYMMETRIC_EN
                        parity       <= 1'b0;
`endif
                    end else begin
                        load0        <= 2'b00;
                        load1        <= 2'b00;
                        load2        <= 2'b00;
                        period_start <= 1'b0;
                        running      <= 1'b0;
                    end
                end
                RUN: begin
                    // en is only honoured at the end of a period.
                    if (at_wrap && !en) begin
                        state        <= IDLE;
                        cnt          <= '0;
                        load0        <= 2'b00;
                        load1        <= 2'b00;
                        load2        <= 2'b00;
                        period_start <= 1'b0;
                        running      <= 1'b0;
                    end else begin
                        cnt          <= next_cnt;
                        load0        <= dec0;
                        load1        <= dec1;
                        load2        <= dec2;
                        period_start <= at_wrap;
                        running      <= 1'b1;
`ifdef MCSCHED_SYMMETRIC_EN
                        parity       <= parity_next;
`endif
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mc_pwm_scheduler.sv
// ---------------------------------------------------------------------------
// tb_mc_pwm_scheduler
//
// Bench for mc_pwm_scheduler. A reference model tracks the schedule as
// "which period are we in, how far into it". The expected load codes come
// from a list of segment lengths derived from the dwell rules. Directed
// scenarios run first, followed by a randomized phase with configuration
// offers, enable toggles and mid-run resets.
// ---------------------------------------------------------------------------
module tb_mc_pwm_scheduler;

    localparam int CNT_W     = 12;
    localparam int MIN_DWELL = 24;

`ifdef MCSCHED_SYMMETRIC_EN
    localparam bit SYM = 1'b1;
`else
    localparam bit SYM = 1'b0;
`endif

    logic                clk;
    logic                rst;
    logic                en;
    logic                cfg_valid;
    logic                cfg_ready;
    logic [CNT_W-1:0]    cfg_period;
    logic [6*CNT_W-1:0]  cfg_duty;
    logic [1:0]          load0;
    logic [1:0]          load1;
    logic [1:0]          load2;
    logic                period_start;
    logic                cfg_err;
    logic                running;

    mc_pwm_scheduler #(
        .CNT_W     (CNT_W),
        .MIN_DWELL (MIN_DWELL)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_period   (cfg_period),
        .cfg_duty     (cfg_duty),
        .load0        (load0),
        .load1        (load1),
        .load2        (load2),
        .period_start (period_start),
        .cfg_err      (cfg_err),
        .running      (running)
    );

    // 50 MHz clock
    initial clk = 1'b0;
    always #10 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Offer currently presented on the configuration port
    int oPer;
    int oDa[3];
    int oDb[3];

    // Reference model state
    bit mRun;
    bit mOdd;
    bit mFull;
    bit mActValid;
    bit mErr;
    int mPos;
    int aPer;
    int aDa[3];
    int aDb[3];
    int sPer;
    int sDa[3];
    int sDb[3];
    bit acceptedLast;

    // Event counters for directed checks
    int psCount;
    int errCount;
    int load0ACount;
    int load1CCount;

    // Compare one observed value against its expectation and report mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
        end
    endtask

    // Expected DesiredLoad of one leg at a position inside the period. The
    // segment lengths follow the dwell rules, and the code is found by walking
    // the ordered list of segments.
    function automatic logic [1:0] expLoad(input int per, input int da, input int db,
                                           input int pos, input bit reverse);
        int la;
        int lb;
        int lc;
        int rem;
        bit shortA;
        bit shortB;
        bit shortC;
        int len[3];
        logic [1:0] ph[3];
        la = da;
        lb = db;
        lc = per - da - db;
        shortA = (la > 0) && (la < MIN_DWELL);
        shortB = (lb > 0) && (lb < MIN_DWELL);
        shortC = (lc > 0) && (lc < MIN_DWELL);
        if (shortB) begin
            lc = lc + lb;
            lb = 0;
        end
        if (shortA) begin
            if (lb > 0) lb = lb + la;
            else        lc = lc + la;
            la = 0;
        end
        if (shortC) begin
            if (lb > 0) begin
                lb = lb + lc;
                lc = 0;
            end else if (la > 0) begin
                la = la + lc;
                lc = 0;
            end
        end
        if (reverse) begin
            len = '{lc, lb, la};
            ph  = '{2'b11, 2'b10, 2'b01};
        end else begin
            len = '{la, lb, lc};
            ph  = '{2'b01, 2'b10, 2'b11};
        end
        rem = pos;
        for (int i = 0; i < 3; i++) begin
            if (rem < len[i]) return ph[i];
            rem = rem - len[i];
        end
        return ph[2];
    endfunction

    function automatic bit offerOk();
        bit ok;
        ok = (oPer >= 2*MIN_DWELL);
        for (int k = 0; k < 3; k++) begin
            if (oDa[k] + oDb[k] > oPer) ok = 1'b0;
        end
        return ok;
    endfunction

    task automatic packOffer();
        cfg_period = CNT_W'(oPer);
        for (int k = 0; k < 3; k++) begin
            cfg_duty[2*k*CNT_W +: CNT_W]     = CNT_W'(oDa[k]);
            cfg_duty[(2*k+1)*CNT_W +: CNT_W] = CNT_W'(oDb[k]);
        end
    endtask

    task automatic modelReset();
        mRun = 0;
        mOdd = 0;
        mFull = 0;
        mActValid = 0;
        mErr = 0;
        mPos = 0;
        acceptedLast = 0;
    endtask

    task automatic applyShadow();
        aPer = sPer;
        for (int k = 0; k < 3; k++) begin
            aDa[k] = sDa[k];
            aDb[k] = sDb[k];
        end
        mActValid = 1;
        mFull = 0;
    endtask

    // One clock edge of the reference model, using the inputs seen at that edge.
    task automatic modelStep();
        bit fullOld;
        fullOld = mFull;
        acceptedLast = 0;
        mErr = 0;
        if (mRun) begin
            if (mPos == aPer - 1) begin
                if (mFull) applyShadow();
                mPos = 0;
                if (!en) mRun = 0;
                else     mOdd = !mOdd;
            end else begin
                mPos++;
            end
        end else begin
            if (mFull) applyShadow();
            if (en && mActValid) begin
                mRun = 1;
                mPos = 0;
                mOdd = 0;
            end
        end
        if (cfg_valid && !fullOld) begin
            acceptedLast = 1;
            if (offerOk()) begin
                sPer = oPer;
                for (int k = 0; k < 3; k++) begin
                    sDa[k] = oDa[k];
                    sDb[k] = oDb[k];
                end
                mFull = 1;
            end else begin
                mErr = 1;
            end
        end
    endtask

    function automatic logic [1:0] expLeg(input int k);
        if (!mRun) return 2'b00;
        return expLoad(aPer, aDa[k], aDb[k], mPos, SYM && mOdd);
    endfunction

    task automatic checkAll();
        checkOutput("load0", {30'd0, load0}, {30'd0, expLeg(0)});
        checkOutput("load1", {30'd0, load1}, {30'd0, expLeg(1)});
        checkOutput("load2", {30'd0, load2}, {30'd0, expLeg(2)});
        checkOutput("period_start", {31'd0, period_start}, {31'd0, (mRun && mPos == 0)});
        checkOutput("running", {31'd0, running}, {31'd0, mRun});
        checkOutput("cfg_ready", {31'd0, cfg_ready}, {31'd0, !mFull});
        checkOutput("cfg_err", {31'd0, cfg_err}, {31'd0, mErr});
        if (period_start === 1'b1) psCount++;
        if (cfg_err === 1'b1) errCount++;
        if (load0 === 2'b01) load0ACount++;
        if (load1 === 2'b11) load1CCount++;
    endtask

    task automatic applyStimulus(input int n);
        repeat (n) begin
            @(posedge clk);
            modelStep();
            @(negedge clk);
            checkAll();
        end
    endtask

    task automatic setOffer(input int per, input int a0, input int b0, input int a1,
                            input int b1, input int a2, input int b2);
        oPer = per;
        oDa[0] = a0; oDb[0] = b0;
        oDa[1] = a1; oDb[1] = b1;
        oDa[2] = a2; oDb[2] = b2;
        packOffer();
    endtask

    // Hold the offer until the transfer happens, with a cycle budget.
    task automatic offerCfg();
        int waitCnt;
        waitCnt = 0;
        cfg_valid = 1'b1;
        applyStimulus(1);
        while (!acceptedLast && waitCnt < 2000) begin
            applyStimulus(1);
            waitCnt++;
        end
        if (!acceptedLast) checkOutput("cfg_accept_timeout", 32'd0, 32'd1);
        cfg_valid = 1'b0;
    endtask

    task automatic waitPeriodStart();
        int waitCnt;
        waitCnt = 0;
        applyStimulus(1);
        while (period_start !== 1'b1 && waitCnt < 1000) begin
            applyStimulus(1);
            waitCnt++;
        end
        if (period_start !== 1'b1) checkOutput("period_start_timeout", 32'd0, 32'd1);
    endtask

    task automatic randomOffer();
        oPer = int'($urandom_range(40, 150));
        for (int k = 0; k < 3; k++) begin
            if ($urandom_range(0, 3) == 0) oDa[k] = int'($urandom_range(0, 30));
            else                           oDa[k] = int'($urandom_range(0, oPer));
            if ($urandom_range(0, 3) == 0) oDb[k] = int'($urandom_range(0, 30));
            else                           oDb[k] = int'($urandom_range(0, oPer - oDa[k] + 4));
        end
        packOffer();
    endtask

    task automatic doReset();
        rst = 1'b0;
        cfg_valid = 1'b0;
        #1;
        modelReset();
        checkAll();
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0;
        en = 1'b0;
        cfg_valid = 1'b0;
        cfg_period = '0;
        cfg_duty = '0;
        modelReset();
        psCount = 0;
        errCount = 0;

        // Reset values
        #15;
        checkAll();
        @(negedge clk);
        rst = 1'b1;

        // Basic 30/30/40 schedule on all legs
        setOffer(100, 30, 30, 30, 30, 30, 30);
        offerCfg();
        applyStimulus(2);
        en = 1'b1;
        psCount = 0;
        applyStimulus(250);
        checkOutput("ps_count_250", psCount, 32'd3);

        // Short A on leg0, short C on leg1, offered mid-period
        setOffer(100, 10, 40, 60, 30, 30, 30);
        offerCfg();
        checkOutput("ready_low_mid_period", {31'd0, cfg_ready}, 32'd0);
        waitPeriodStart();
        checkOutput("ready_back_at_start", {31'd0, cfg_ready}, 32'd1);
        load0ACount = 0;
        load1CCount = 0;
        applyStimulus(199);
        checkOutput("leg0_never_A", load0ACount, 32'd0);
        checkOutput("leg1_never_C", load1CCount, 32'd0);

        // Rejected configuration
        errCount = 0;
        setOffer(100, 70, 40, 70, 40, 70, 40);
        offerCfg();
        applyStimulus(5);
        checkOutput("cfg_err_count", errCount, 32'd1);
        checkOutput("ready_after_reject", {31'd0, cfg_ready}, 32'd1);

        // Enable dropped mid-period
        en = 1'b0;
        applyStimulus(250);
        checkOutput("stopped_running", {31'd0, running}, 32'd0);
        checkOutput("stopped_load0", {30'd0, load0}, 32'd0);

        // Randomized phase
        en = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            if (!cfg_valid && $urandom_range(0, 39) == 0) begin
                randomOffer();
                cfg_valid = 1'b1;
            end
            if ($urandom_range(0, 199) == 0) en = ~en;
            if ($urandom_range(0, 1499) == 0) doReset();
            applyStimulus(1);
            if (acceptedLast) cfg_valid = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
